// File: rtl/residual_sequencer.sv
// residual_sequencer
// Per-subframe controller for the residual decoder. On a start request it reads the
// 6-bit residual coding header (method, partition order) from sample RAM, validates
// it against the block configuration, hands the decoder its start position and then
// counts residuals until iBlockSize - iPredictorOrder have been emitted.
//
// Ports:
//   iClock, iReset            clock, asynchronous active-low reset
//   iStart                    start pulse (honoured only when idle)
//   iBlockSize, iPredictorOrder, iStartAddr, iStartBit   block config, latched on iStart
//   iData                     RAM read data (one-cycle latency)
//   oReadAddr                 RAM address (own fetch address, or iDecReadAddr while running)
//   oDecReset, oDecEnable     decoder control
//   oDecPartitionOrder, oDecRice2, oDecStartAddr, oDecStartBit   decoder config
//   iDecReadAddr, iDecResidual, iDecDone   decoder interface
//   oResidual, oValid, oDone  registered residual stream, oDone marks the last one
//   oError                    header/config error, held until next accepted start
//   oBusy                     high whenever not idle
module residual_sequencer (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iStart,
  input  logic [15:0] iBlockSize,
  input  logic [3:0]  iPredictorOrder,
  input  logic [15:0] iStartAddr,
  input  logic [3:0]  iStartBit,
  input  logic [15:0] iData,
  output logic [15:0] oReadAddr,
  output logic        oDecReset,
  output logic        oDecEnable,
  output logic [3:0]  oDecPartitionOrder,
  output logic        oDecRice2,
  output logic [15:0] oDecStartAddr,
  output logic [4:0]  oDecStartBit,
  input  logic [15:0] iDecReadAddr,
  input  logic [15:0] iDecResidual,
  input  logic        iDecDone,
  output logic [15:0] oResidual,
  output logic        oValid,
  output logic        oDone,
  output logic        oError,
  output logic        oBusy
);

  typedef enum logic [3:0] {
    StIdle, StFetch, StRead0, StRead1, StCheck, StLaunch, StRun, StDone, StError
  } state_e;

  state_e      r_state, w_next;
  logic [15:0] r_block_size;
  logic [3:0]  r_order;
  logic [15:0] r_start_addr;
  logic [3:0]  r_start_bit;
  logic [15:0] r_own_addr;
  logic [15:0] r_w0, r_w1;
  logic [15:0] r_count;
  logic [3:0]  r_porder;
  logic        r_rice2;
  logic [15:0] r_dec_addr;
  logic [4:0]  r_dec_bit;
  logic [15:0] r_residual;
  logic        r_valid, r_done, r_error;

  logic        w_straddle;
  logic [31:0] w_pair;
  logic [4:0]  w_shamt;
  logic [5:0]  w_header;
  logic [3:0]  w_porder;
  logic [15:0] w_mask, w_part, w_target, w_count_inc;
  logic        w_err, w_last;

  // Header MSB sits at bit b of word A, i.e. bit b+16 of {A, A+1}; LSB is 5 bits lower.
  assign w_straddle  = (r_start_bit < 4'd5);
  assign w_pair      = {r_w0, r_w1};
  assign w_shamt     = {1'b0, r_start_bit} + 5'd11;
  assign w_header    = w_pair[w_shamt +: 6];
  assign w_porder    = w_header[3:0];
  assign w_mask      = (16'd1 << w_porder) - 16'd1;
  assign w_part      = r_block_size >> w_porder;
  // Method >= 2, block not divisible into partitions, or first partition has no residuals.
  assign w_err       = w_header[5] | (|(r_block_size & w_mask)) |
                       (w_part <= {12'd0, r_order});
  assign w_target    = r_block_size - {12'd0, r_order};
  assign w_count_inc = r_count + 16'd1;
  assign w_last      = iDecDone && (w_count_inc == w_target);

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) r_state <= StIdle;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      StIdle:   if (iStart) w_next = StFetch;
      StFetch:  w_next = StRead0;
      StRead0:  w_next = w_straddle ? StRead1 : StCheck;
      StRead1:  w_next = StCheck;
      StCheck:  w_next = w_err ? StError : StLaunch;
      StLaunch: w_next = StRun;
      StRun:    if (w_last) w_next = StDone;
      StDone:   w_next = StIdle;
      StError:  w_next = StIdle;
      default:  w_next = StIdle;
    endcase
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_block_size <= 16'd0;
      r_order      <= 4'd0;
      r_start_addr <= 16'd0;
      r_start_bit  <= 4'd0;
      r_own_addr   <= 16'd0;
      r_w0         <= 16'd0;
      r_w1         <= 16'd0;
      r_count      <= 16'd0;
      r_porder     <= 4'd0;
      r_rice2      <= 1'b0;
      r_dec_addr   <= 16'd0;
      r_dec_bit    <= 5'd0;
      r_residual   <= 16'd0;
      r_valid      <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (iStart) begin
            r_block_size <= iBlockSize;
            r_order      <= iPredictorOrder;
            r_start_addr <= iStartAddr;
            r_start_bit  <= iStartBit;
            r_own_addr   <= iStartAddr;
            r_count      <= 16'd0;
            r_error      <= 1'b0;
          end
        end
        StFetch: begin
          // Present A+1 during READ0 so its data is ready for READ1.
          if (w_straddle) r_own_addr <= r_start_addr + 16'd1;
        end
        StRead0: r_w0 <= iData;
        StRead1: r_w1 <= iData;
        StCheck: begin
          r_porder   <= w_porder;
          r_rice2    <= w_header[4];
          r_dec_addr <= r_start_addr + {15'd0, (r_start_bit < 4'd6)};
          r_dec_bit  <= {1'b0, r_start_bit - 4'd6};
          if (w_err) r_error <= 1'b1;
        end
        StRun: begin
          if (iDecDone) begin
            r_valid    <= 1'b1;
            r_residual <= iDecResidual;
            r_count    <= w_count_inc;
            r_done     <= w_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign oReadAddr          = (r_state == StRun) ? iDecReadAddr : r_own_addr;
  assign oDecReset          = (r_state != StRun);
  assign oDecEnable         = (r_state == StRun);
  assign oDecPartitionOrder = r_porder;
  assign oDecRice2          = r_rice2;
  assign oDecStartAddr      = r_dec_addr;
  assign oDecStartBit       = r_dec_bit;
  assign oResidual          = r_residual;
  assign oValid             = r_valid;
  assign oDone              = r_done;
  assign oError             = r_error;
  assign oBusy              = (r_state != StIdle);

endmodule

// File: tb/tb_residual_sequencer.sv
// Directed testbench for residual_sequencer: RAM model with one-cycle read latency,
// decoder strobes driven from tasks, expected values hand-derived from the header words.
module tb_residual_sequencer;

  logic        iClock = 1'b0;
  logic        iReset = 1'b0;
  logic        iStart = 1'b0;
  logic [15:0] iBlockSize = 16'd0;
  logic [3:0]  iPredictorOrder = 4'd0;
  logic [15:0] iStartAddr = 16'd0;
  logic [3:0]  iStartBit = 4'd0;
  logic [15:0] iData;
  logic [15:0] oReadAddr;
  logic        oDecReset, oDecEnable, oDecRice2;
  logic [3:0]  oDecPartitionOrder;
  logic [15:0] oDecStartAddr;
  logic [4:0]  oDecStartBit;
  logic [15:0] iDecReadAddr = 16'hBEEF;
  logic [15:0] iDecResidual = 16'd0;
  logic        iDecDone = 1'b0;
  logic [15:0] oResidual;
  logic        oValid, oDone, oError, oBusy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] mem [0:255];

  always #5 iClock = ~iClock;

  always @(posedge iClock) iData <= mem[oReadAddr[7:0]];

  residual_sequencer dut (
    .iClock(iClock), .iReset(iReset), .iStart(iStart), .iBlockSize(iBlockSize),
    .iPredictorOrder(iPredictorOrder), .iStartAddr(iStartAddr), .iStartBit(iStartBit),
    .iData(iData), .oReadAddr(oReadAddr), .oDecReset(oDecReset), .oDecEnable(oDecEnable),
    .oDecPartitionOrder(oDecPartitionOrder), .oDecRice2(oDecRice2),
    .oDecStartAddr(oDecStartAddr), .oDecStartBit(oDecStartBit), .iDecReadAddr(iDecReadAddr),
    .iDecResidual(iDecResidual), .iDecDone(iDecDone), .oResidual(oResidual),
    .oValid(oValid), .oDone(oDone), .oError(oError), .oBusy(oBusy)
  );

  // Pulse iStart so that it is sampled at edge E0; returns at E0 + 1.
  task automatic do_start(input logic [15:0] bs, input logic [3:0] ord,
                          input logic [15:0] addr, input logic [3:0] sbit);
    @(posedge iClock); #1;
    iBlockSize = bs; iPredictorOrder = ord; iStartAddr = addr; iStartBit = sbit;
    iStart = 1'b1;
    @(posedge iClock); #1;
    iStart = 1'b0;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge iClock); #1;
    end
  endtask

  // Feed n decoder strobes with 'gap' idle cycles after each; tallies what came back.
  task automatic feed(input int n, input int gap, output int bad, output int valids,
                      output int done_idx);
    logic [15:0] exp;
    bad = 0; valids = 0; done_idx = -1;
    for (int i = 0; i < n; i++) begin
      exp = 16'(i * 7 + 3);
      iDecDone = 1'b1; iDecResidual = exp;
      @(posedge iClock); #1;
      if (oValid === 1'b1) valids++; else bad++;
      if (oResidual !== exp) bad++;
      if (oDone === 1'b1 && done_idx < 0) done_idx = i;
      for (int g = 0; g < gap; g++) begin
        iDecDone = 1'b0;
        @(posedge iClock); #1;
        if (oValid !== 1'b0) bad++;
      end
    end
    iDecDone = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (oBusy !== 1'b0) $display("FAIL rst_busy got %b want 0", oBusy); else n_pass++;
    n_checks++; if (oDecReset !== 1'b1) $display("FAIL rst_decreset got %b want 1", oDecReset); else n_pass++;
    n_checks++; if ({oDecEnable, oValid, oDone, oError} !== 4'b0000)
      $display("FAIL rst_flags got %b want 0000", {oDecEnable, oValid, oDone, oError}); else n_pass++;
    n_checks++; if (oReadAddr !== 16'd0) $display("FAIL rst_addr got %h want 0000", oReadAddr); else n_pass++;
    @(posedge iClock); #1;
    iReset = 1'b1;
  endtask

  task automatic test_basic();
    int bad, valids, didx;
    mem[0] = 16'h29A5;
    do_start(16'd4096, 4'd0, 16'h0000, 4'd15);
    n_checks++; if (oBusy !== 1'b1) $display("FAIL basic_fetch_busy got %b want 1", oBusy); else n_pass++;
    n_checks++; if (oReadAddr !== 16'h0000) $display("FAIL basic_fetch_addr got %h want 0000", oReadAddr); else n_pass++;
    step(3); // LAUNCH
    n_checks++; if ({oDecEnable, oDecReset} !== 2'b01)
      $display("FAIL basic_launch_ctrl got %b want 01", {oDecEnable, oDecReset}); else n_pass++;
    n_checks++; if (oDecPartitionOrder !== 4'd10) $display("FAIL basic_porder got %0d want 10", oDecPartitionOrder); else n_pass++;
    n_checks++; if (oDecRice2 !== 1'b0) $display("FAIL basic_rice2 got %b want 0", oDecRice2); else n_pass++;
    n_checks++; if (oDecStartAddr !== 16'h0000) $display("FAIL basic_saddr got %h want 0000", oDecStartAddr); else n_pass++;
    n_checks++; if (oDecStartBit !== 5'd9) $display("FAIL basic_sbit got %0d want 9", oDecStartBit); else n_pass++;
    step(1); // E4: RUN
    n_checks++; if ({oDecEnable, oDecReset} !== 2'b10)
      $display("FAIL basic_run_ctrl got %b want 10", {oDecEnable, oDecReset}); else n_pass++;
    n_checks++; if (oReadAddr !== 16'hBEEF) $display("FAIL basic_run_addr got %h want beef", oReadAddr); else n_pass++;
    // A start while busy must not disturb the running block.
    iStart = 1'b1; iBlockSize = 16'd16; iPredictorOrder = 4'd2;
    step(1);
    iStart = 1'b0;
    n_checks++; if (oDecEnable !== 1'b1) $display("FAIL busy_start_enable got %b want 1", oDecEnable); else n_pass++;
    feed(4096, 1, bad, valids, didx);
    n_checks++; if (bad !== 0) $display("FAIL basic_stream_bad got %0d want 0", bad); else n_pass++;
    n_checks++; if (valids !== 4096) $display("FAIL basic_valids got %0d want 4096", valids); else n_pass++;
    n_checks++; if (didx !== 4095) $display("FAIL basic_done_idx got %0d want 4095", didx); else n_pass++;
    n_checks++; if (oBusy !== 1'b0) $display("FAIL basic_idle_after got %b want 0", oBusy); else n_pass++;
  endtask

  task automatic test_straddle();
    int bad, valids, didx;
    mem[8'h20] = 16'h0002;
    mem[8'h21] = 16'h4000;
    do_start(16'd512, 4'd0, 16'h0020, 4'd3);
    n_checks++; if (oReadAddr !== 16'h0020) $display("FAIL strad_fetch_addr got %h want 0020", oReadAddr); else n_pass++;
    step(1); // READ0
    n_checks++; if (oReadAddr !== 16'h0021) $display("FAIL strad_read0_addr got %h want 0021", oReadAddr); else n_pass++;
    step(3); // E4: LAUNCH
    n_checks++; if (oDecEnable !== 1'b0) $display("FAIL strad_e4_enable got %b want 0", oDecEnable); else n_pass++;
    n_checks++; if (oDecPartitionOrder !== 4'd9) $display("FAIL strad_porder got %0d want 9", oDecPartitionOrder); else n_pass++;
    n_checks++; if (oDecStartAddr !== 16'h0021) $display("FAIL strad_saddr got %h want 0021", oDecStartAddr); else n_pass++;
    n_checks++; if (oDecStartBit !== 5'd13) $display("FAIL strad_sbit got %0d want 13", oDecStartBit); else n_pass++;
    step(1); // E5: RUN
    n_checks++; if (oDecEnable !== 1'b1) $display("FAIL strad_e5_enable got %b want 1", oDecEnable); else n_pass++;
    feed(512, 0, bad, valids, didx);
    n_checks++; if (bad !== 0 || didx !== 511)
      $display("FAIL strad_stream got bad=%0d done_idx=%0d want bad=0 done_idx=511", bad, didx); else n_pass++;
  endtask

  task automatic test_error();
    mem[8'h40] = 16'h8000; // method 10
    do_start(16'd4096, 4'd0, 16'h0040, 4'd15);
    step(2); // CHECK
    n_checks++; if (oError !== 1'b0) $display("FAIL err_e2 got %b want 0", oError); else n_pass++;
    step(1); // E3: ERROR
    n_checks++; if ({oError, oBusy, oDecEnable} !== 3'b110)
      $display("FAIL err_e3 got %b want 110", {oError, oBusy, oDecEnable}); else n_pass++;
    step(1); // E4: IDLE
    n_checks++; if ({oError, oBusy} !== 2'b10) $display("FAIL err_e4 got %b want 10", {oError, oBusy}); else n_pass++;
    // porder 10, 4096 >> 10 = 4 <= order 4: error; the start itself clears oError first.
    do_start(16'd4096, 4'd4, 16'h0000, 4'd15);
    n_checks++; if (oError !== 1'b0) $display("FAIL err_clear got %b want 0", oError); else n_pass++;
    step(3);
    n_checks++; if ({oError, oDecEnable} !== 2'b10)
      $display("FAIL err_order got %b want 10", {oError, oDecEnable}); else n_pass++;
    step(1);
    // 4095 is not a multiple of 2^10.
    do_start(16'd4095, 4'd0, 16'h0000, 4'd15);
    step(3);
    n_checks++; if ({oError, oDecEnable} !== 2'b10)
      $display("FAIL err_align got %b want 10", {oError, oDecEnable}); else n_pass++;
    step(1);
  endtask

  task automatic test_order3();
    int bad, valids, didx;
    do_start(16'd4096, 4'd3, 16'h0000, 4'd15);
    step(4);
    n_checks++; if ({oError, oDecEnable} !== 2'b01)
      $display("FAIL ord3_run got %b want 01", {oError, oDecEnable}); else n_pass++;
    feed(4093, 0, bad, valids, didx);
    n_checks++; if (bad !== 0 || valids !== 4093 || didx !== 4092)
      $display("FAIL ord3_stream got bad=%0d valids=%0d done_idx=%0d want 0/4093/4092",
               bad, valids, didx); else n_pass++;
    step(1);
  endtask

  task automatic test_back_to_back();
    int bad, valids, didx;
    do_start(16'd4096, 4'd0, 16'h0000, 4'd15);
    step(4);
    feed(4096, 0, bad, valids, didx);
    n_checks++; if (bad !== 0 || valids !== 4096 || didx !== 4095)
      $display("FAIL b2b_stream got bad=%0d valids=%0d done_idx=%0d want 0/4096/4095",
               bad, valids, didx); else n_pass++;
    n_checks++; if ({oDecEnable, oDecReset} !== 2'b01)
      $display("FAIL b2b_after_done got %b want 01", {oDecEnable, oDecReset}); else n_pass++;
    iDecDone = 1'b1; // strobe outside RUN is ignored
    step(1);
    n_checks++; if (oValid !== 1'b0) $display("FAIL b2b_extra_valid got %b want 0", oValid); else n_pass++;
    iDecDone = 1'b0;
  endtask

  task automatic test_midrun_reset();
    int bad, valids, didx;
    do_start(16'd4096, 4'd0, 16'h0000, 4'd15);
    step(4);
    feed(100, 0, bad, valids, didx);
    n_checks++; if (bad !== 0 || didx !== -1)
      $display("FAIL mrst_prefix got bad=%0d done_idx=%0d want 0/-1", bad, didx); else n_pass++;
    iDecDone = 1'b1;
    #2 iReset = 1'b0;
    #1;
    n_checks++; if ({oBusy, oDecReset, oDecEnable, oValid, oDone} !== 5'b01000)
      $display("FAIL mrst_async got %b want 01000", {oBusy, oDecReset, oDecEnable, oValid, oDone}); else n_pass++;
    n_checks++; if (oReadAddr !== 16'd0 || oDecPartitionOrder !== 4'd0)
      $display("FAIL mrst_regs got addr=%h porder=%0d want 0/0", oReadAddr, oDecPartitionOrder); else n_pass++;
    @(posedge iClock); #1;
    iReset = 1'b1;
    step(2);
    n_checks++; if ({oValid, oBusy} !== 2'b00) $display("FAIL mrst_quiet got %b want 00", {oValid, oBusy}); else n_pass++;
    iDecDone = 1'b0;
    do_start(16'd4096, 4'd0, 16'h0000, 4'd15);
    step(4);
    feed(4096, 0, bad, valids, didx);
    n_checks++; if (bad !== 0 || valids !== 4096 || didx !== 4095)
      $display("FAIL mrst_fresh got bad=%0d valids=%0d done_idx=%0d want 0/4096/4095",
               bad, valids, didx); else n_pass++;
    step(1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'd0;
    test_reset();
    test_basic();
    test_straddle();
    test_error();
    test_order3();
    test_back_to_back();
    test_midrun_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/residual_sequencer.md
# residual_sequencer

Per-subframe controller for the residual decoder.
- On a start request it fetches and parses the 6-bit residual coding header (2-bit coding method, 4-bit partition order) from sample RAM, validates it, and derives the decoder's start word/bit.
- It then releases and enables the decoder, owning the RAM read-address mux throughout.
- It counts emitted residuals and stops the decoder after exactly iBlockSize − iPredictorOrder residuals.
- It sits between the subframe/frame parser and the residual decoder + RAM.

## Interface
Parameters: none (widths fixed: 16-bit RAM words, 16-bit addresses, 16-bit residuals).
- iClock  in  1  system clock, all logic on rising edge
- iReset  in  1  asynchronous, active-low reset
- iStart  in  1  one-cycle start pulse; honoured only in IDLE
- iBlockSize  in  16  samples in block; sampled on iStart
- iPredictorOrder  in  4  warm-up samples preceding residuals; sampled on iStart
- iStartAddr  in  16  word address holding header MSB; sampled on iStart
- iStartBit  in  4  bit index (15..0) of header MSB in that word; sampled on iStart
- iData  in  16  RAM read data (1-cycle latency)
- oReadAddr  out  16  RAM read address (own address, or iDecReadAddr in RUN)
- oDecReset  out  1  active-high reset to residual decoder
- oDecEnable  out  1  decoder enable
- oDecPartitionOrder  out  4  parsed partition order
- oDecRice2  out  1  coding method bit 0 (1 = 5-bit Rice parameters)
- oDecStartAddr  out  16  first word after header
- oDecStartBit  out  5  first bit after header; bit 4 always 0
- iDecReadAddr  in  16  decoder RAM address
- iDecResidual  in  16  signed residual from decoder
- iDecDone  in  1  decoder residual-valid strobe
- oResidual  out  16  registered residual
- oValid  out  1  registered residual-valid
- oDone  out  1  one-cycle pulse with the final oValid
- oError  out  1  header/config error; held until next accepted iStart
- oBusy  out  1  high in every state except IDLE

## Operation
States:
- IDLE → FETCH on iStart; inputs are latched, the count is cleared, and oError is cleared.
- FETCH → READ0.
- READ0 → READ1 if straddle, else CHECK.
- READ1 → CHECK.
- CHECK → ERROR or LAUNCH.
- LAUNCH → RUN.
- RUN → DONE.
- DONE → IDLE.
- ERROR → IDLE.

Address and header rules:
- FETCH drives oReadAddr = A. READ0 captures word A.
- Straddle means iStartBit < 5. In that case READ0 also drives A+1, and READ1 captures word A+1.
- The header is the 6 bits starting at bit b = iStartBit of word A, continuing MSB-first into word A+1.
- Next position: oDecStartBit = (b − 6) mod 16; oDecStartAddr = A + (b < 6).

CHECK raises an error if any of the following holds:
- coding method ≥ 2;
- iBlockSize is not a multiple of 2^porder;
- (iBlockSize >> porder) ≤ iPredictorOrder.

On error, ERROR sets oError. The decoder is never enabled.

Decoder control:
- oDecReset = 1 in all states except RUN. oDecEnable = 1 only in RUN.
- The decoder config outputs are registered in CHECK and stay stable through RUN.
- LAUNCH is a single cycle with config valid and reset still asserted.
- oReadAddr = iDecReadAddr in RUN; otherwise it is the sequencer's own address (hold the last value).

Counting:
- In RUN, each iDecDone produces, at the next edge, oValid = 1, oResidual = iDecResidual, and count + 1.
- Target = iBlockSize − iPredictorOrder, 16-bit unsigned.
- When the strobe that makes count == target is registered, oDone = 1 together with that oValid. The state goes to DONE, which drops enable and asserts decoder reset.
- iDecDone outside RUN is ignored.

## Timing
- Reset values: state IDLE; oDecReset = 1; all other outputs 0; count 0.
- iStart at edge E0 → FETCH in cycle E0..E1.
- First RUN cycle begins at E4 (no straddle) or E5 (straddle).
- Error: oError rises at E3 or E4.
- Throughput is limited only by the decoder; back-to-back iDecDone strobes are accepted every cycle.
- Next iStart is accepted the cycle after DONE or ERROR returns to IDLE.
- iStart while busy is ignored.
- Reset asserted mid-RUN: immediately IDLE, oDecReset = 1, oValid/oDone = 0, no further outputs.

## Test plan
- A=0, bit 15, word 0x29A5, iBlockSize 4096, order 0 → porder 10, oDecStartAddr 0, oDecStartBit 9, RUN at E4, exactly 4096 oValid, oDone on the 4096th.
- Straddle: A=0x20, bit 3, word[3:0]=0010, word 0x21[15:14]=01 → porder 9, oDecStartAddr 0x21, oDecStartBit 13, RUN at E5.
- Method bits 10 → oError at E3, oDecEnable never high, oBusy low at E4; the next iStart clears oError.
- iBlockSize 4096, porder 10: order 4 → oError; order 3 → 4093 residuals then oDone.
- iDecDone held high continuously → 4096 consecutive oValid, oDone on the last, oDecEnable low the following cycle.
- iReset low at residual 100 of a run → all outputs at reset values asynchronously; a fresh iStart completes a full block normally.
